// File: rtl/ifu_axi_fetch_pkg.sv
// Shared types and constants for the AXI4 instruction fetch stage.
package ifu_axi_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StHold,
    StDrain
  } fetch_state_e;

  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultBus      = 2'b10
  } fault_e;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [2:0] AxiSize4B    = 3'b010;
  localparam logic [1:0] AxiRespOkay  = 2'b00;
  localparam logic [7:0] AxiLenSingle = 8'd0;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// AXI4 read-address and read-data channels used by the fetch stage.
interface ifu_axi_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch: takes a PC, issues one single-beat AXI read, hands the
// instruction (or a fault) to the decoder; flush drains any in-flight read.
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  AXI_ID = 4'd0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [1:0]        fault_o,
  ifu_axi_fetch_if.master   axi
);

  fetch_state_e      state_q, state_d;
  logic              killed_q, killed_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  fault_e            fault_q, fault_d;
  logic              pc_accept;
  logic              r_match;

  assign pc_ready_o = !flush_i && (state_q == StIdle || (state_q == StHold && inst_ready_i));
  assign pc_accept  = pc_valid_i && pc_ready_o;
  assign r_match    = axi.rvalid && (axi.rid == AXI_ID);

  always_comb begin
    state_d   = state_q;
    killed_d  = killed_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    araddr_d  = araddr_q;
    fault_d   = fault_q;

    unique case (state_q)
      StIdle: ;
      StHold: begin
        if (flush_i || inst_ready_i) state_d = StIdle;
      end
      StAddr: begin
        // The AR cannot be withdrawn, so a flush only marks the beat for discard.
        killed_d = killed_q || flush_i;
        if (axi.arready) state_d = (killed_q || flush_i) ? StDrain : StData;
      end
      StData: begin
        if (r_match) begin
          killed_d = 1'b0;
          if (flush_i || killed_q) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            inst_d  = axi.rdata[31:0];
            fault_d = (axi.rresp != AxiRespOkay || !axi.rlast) ? FaultBus : FaultNone;
          end
        end else if (flush_i) begin
          killed_d = 1'b1;
        end
      end
      StDrain: begin
        if (r_match) begin
          state_d  = StIdle;
          killed_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept only happens from IDLE or a consumed HOLD, so it overrides the above.
    if (pc_accept) begin
      inst_pc_d = pc_i;
      if (is_misaligned(pc_i[1:0])) begin
        state_d = StHold;
        fault_d = FaultMisalign;
        inst_d  = '0;
      end else begin
        state_d  = StAddr;
        araddr_d = pc_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      killed_q  <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      araddr_q  <= '0;
      fault_q   <= FaultNone;
    end else begin
      state_q   <= state_d;
      killed_q  <= killed_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      araddr_q  <= araddr_d;
      fault_q   <= fault_d;
    end
  end

  assign axi.arvalid   = (state_q == StAddr);
  assign axi.araddr    = araddr_q;
  assign axi.arid      = AXI_ID;
  assign axi.arlen     = AxiLenSingle;
  assign axi.arsize    = AxiSize4B;
  assign axi.arburst   = AxiBurstIncr;
  assign axi.rready    = (state_q == StData) || (state_q == StDrain);

  assign inst_valid_o  = (state_q == StHold);
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign fault_o       = fault_q;

endmodule

// File: doc/ifu_axi_fetch.md
Name: ifu_axi_fetch

Overview:
- AXI4 read-master instruction fetch stage between pcu and idu.
- Accepts a PC over valid/ready and issues a single-beat AXI read on the core's master port via icn.
- Returns the 32-bit instruction with its PC and a fault code to the decoder over valid/ready.
- Supports flush (redirect) with correct draining of in-flight bus transactions.

Parameters:
- ADDR_W, 32, PC/AXI address width
- DATA_W, 32, AXI data width; instruction taken from bits [31:0]
- AXI_ID, 0, 4-bit ID driven on arid_o and expected on rid_i

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- pc_valid_i  in  1  PC offered by pcu
- pc_i  in  ADDR_W  fetch address
- pc_ready_o  out  1  PC accepted when pc_valid_i && pc_ready_o
- flush_i  in  1  discard the current fetch/output (redirect)
- inst_valid_o  out  1  instruction available to idu
- inst_ready_i  in  1  idu accepts
- inst_o  out  32  fetched instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- fault_o  out  2  00 none, 01 misaligned, 10 bus error
- arvalid_o / arready_i / araddr_o[ADDR_W] / arid_o[4] / arlen_o[8] / arsize_o[3] / arburst_o[2]  AXI AR channel
- rvalid_i / rready_o / rdata_i[DATA_W] / rresp_i[2] / rlast_i / rid_i[4]  AXI R channel

Behaviour:
- Reset (rst_i==0 at posedge): state IDLE. arvalid_o, rready_o, inst_valid_o, killed flag all 0. inst_o, inst_pc_o, fault_o, araddr_o = 0.
- Constants: arlen_o=0, arsize_o=3'b010, arburst_o=2'b01, arid_o=AXI_ID.
- States: IDLE, ADDR, DATA, HOLD, DRAIN.
- pc_ready_o = !flush_i && (state==IDLE || (state==HOLD && inst_ready_i)). Combinational.
- IDLE / HOLD accept: latch pc_i.
  - pc_i[1:0]!=0 -> HOLD with fault=01, inst=0; no bus access.
  - Otherwise -> ADDR.
- ADDR: arvalid_o=1; araddr_o stable until arready_i.
  - On handshake -> DATA, or DRAIN if killed.
  - flush_i here sets killed; arvalid_o is never withdrawn before handshake.
- DATA: rready_o=1.
  - Beat with rid_i!=AXI_ID: accepted, discarded, stay in DATA.
  - Matching beat: inst_o=rdata_i[31:0]; fault=10 if rresp_i!=0 or rlast_i==0, else 00.
  - Then -> HOLD, or -> IDLE with no output if flush_i or killed this cycle.
- DRAIN: rready_o=1; first matching beat discarded -> IDLE; killed cleared.
- HOLD: inst_valid_o=1; inst_o, inst_pc_o, fault_o held stable until inst_ready_i.
  - Handshake with no new PC -> IDLE; handshake with new PC -> ADDR/HOLD per accept rule.
  - flush_i in HOLD -> IDLE; inst_valid_o low next cycle, even if inst_ready_i was high.
- flush_i in IDLE: no PC accepted.
- Latency: PC accepted at cycle N, arready at N+1, rvalid at N+2 -> inst_valid_o at N+3. Throughput: one fetch per 3 cycles minimum.
- At most one outstanding AR. A new AR is issued only after its R beat is consumed.
- Reset mid-transaction abandons it; arvalid_o drops. Stale R beats are the responsibility of the shared-reset interconnect.

Decomposition:
- Shared defines/typedefs: fetch state encoding, fault codes (none/misaligned/bus), AXI burst INCR and size-4B constants, AXI OKAY resp value.
- Single module; no sub-module warranted.

Test Plan:
- Aligned fetch: pc_i=0x80000000, arready immediate, rdata=0x00000413, rresp=0, rlast=1 -> inst_valid_o at N+3; inst_o=0x00000413, inst_pc_o=0x80000000, fault_o=00.
- Misaligned: pc_i=0x80000002 -> no arvalid_o ever; inst_valid_o next cycle with fault_o=01, inst_o=0.
- Bus error and backpressure:
  - rresp=2'b10 -> fault_o=10.
  - inst_ready_i held low 5 cycles -> all outputs stable, pc_ready_o=0.
  - Release -> back-to-back accept of pc 0x80000004.
- Flush in ADDR with arready delayed 4 cycles:
  - arvalid_o stays high with araddr unchanged.
  - The R beat is drained; no inst_valid_o.
  - Next PC fetches normally.
- Foreign ID: beat with rid=5 and then rid=AXI_ID -> only the second is returned.
- Reset mid-DATA: rst_i low one cycle -> all outputs 0, state IDLE, pc_ready_o=1 the following cycle.
